// File: rtl/reg_incr_pkg.sv
// Shared types and helpers for the registered N-stage incrementer.
// REG_INCR_NSTAGE_PIPE_SAT_EN selects saturating instead of wrapping add.
package reg_incr_pkg;

   localparam int unsigned XW = 64;

   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic logic [XW-1:0] lo_mask(input int unsigned w);
      return (w >= XW) ? '1 : ((XW'(1) << w) - XW'(1));
   endfunction

   function automatic logic [XW-1:0] incr_wrap(
      input logic [XW-1:0] x,
      input logic [XW-1:0] amt,
      input int unsigned   w
   );
      return (x + amt) & lo_mask(w);
   endfunction

   function automatic logic [XW-1:0] incr_sat(
      input logic [XW-1:0] x,
      input logic [XW-1:0] amt,
      input int unsigned   w
   );
      logic [XW:0] s;
      s = {1'b0, x} + {1'b0, amt};
      return (s > {1'b0, lo_mask(w)}) ? lo_mask(w) : s[XW-1:0];
   endfunction

   function automatic logic [XW-1:0] incr(
      input logic [XW-1:0] x,
      input logic [XW-1:0] amt,
      input int unsigned   w
   );
`ifdef REG_INCR_NSTAGE_PIPE_SAT_EN
      return incr_sat(x, amt, w);
`else
      return incr_wrap(x, amt, w);
`endif
   endfunction

endpackage

// File: rtl/reg_incr_pipe_stage.sv
// One pipeline stage: valid + message register loaded with incr(src) on go.
// Arithmetic mode follows REG_INCR_NSTAGE_PIPE_SAT_EN via the package.
module reg_incr_pipe_stage
   import reg_incr_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned INCR_AMT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic             in_val,
   input  logic [WIDTH-1:0] in_msg,
   output logic             val,
   output logic [WIDTH-1:0] msg
);

   typedef struct packed {
      logic             val;
      logic [WIDTH-1:0] msg;
   } stage_t;

   stage_t           q;
   logic [WIDTH-1:0] nxt;

   assign nxt = WIDTH'(incr(XW'(in_msg), XW'(INCR_AMT), WIDTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (go) begin
         q <= {in_val, nxt};
      end
   end

   assign val = q.val;
   assign msg = q.msg;

endmodule

// File: rtl/reg_incr_nstage_pipe.sv
// N-stage registered incrementer with val/rdy, bubble collapsing, occupancy.
// Define REG_INCR_NSTAGE_PIPE_SAT_EN for saturating arithmetic.
module reg_incr_nstage_pipe
   import reg_incr_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned NSTAGES  = 2,
   parameter int unsigned INCR_AMT = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_val,
   output logic                           in_rdy,
   input  logic [WIDTH-1:0]               in_msg,
   output logic                           out_val,
   input  logic                           out_rdy,
   output logic [WIDTH-1:0]               out_msg,
   output logic [$clog2(NSTAGES+1)-1:0]   count
);

   localparam int unsigned CW = cnt_w(NSTAGES);

   logic [NSTAGES-1:0] val;
   logic [NSTAGES-1:0] go;
   logic [WIDTH-1:0]   msg [NSTAGES];
   logic               in_xfer;
   logic               out_xfer;

   // Ready ripples back from the sink; any empty slot lets upstream advance.
   always_comb begin
      logic g;
      g  = out_rdy;
      go = '0;
      for (int i = NSTAGES - 1; i >= 0; i--) begin
         g     = g | ~val[i];
         go[i] = g;
      end
   end

   for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
         reg_incr_pipe_stage #(
            .WIDTH    (WIDTH),
            .INCR_AMT (INCR_AMT)
         ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .go     (go[i]),
            .in_val (in_val),
            .in_msg (in_msg),
            .val    (val[i]),
            .msg    (msg[i])
         );
      end else begin : g_body
         reg_incr_pipe_stage #(
            .WIDTH    (WIDTH),
            .INCR_AMT (INCR_AMT)
         ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .go     (go[i]),
            .in_val (val[i-1]),
            .in_msg (msg[i-1]),
            .val    (val[i]),
            .msg    (msg[i])
         );
      end
   end

   assign in_rdy   = go[0];
   assign out_val  = val[NSTAGES-1];
   assign out_msg  = msg[NSTAGES-1];
   assign in_xfer  = in_val & in_rdy;
   assign out_xfer = out_val & out_rdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (in_xfer && !out_xfer) begin
         count <= count + CW'(1);
      end else if (!in_xfer && out_xfer) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_reg_incr_nstage_pipe.sv
// Bench for reg_incr_nstage_pipe: directed scenarios plus random traffic
// scored against a queue model; a second instance covers depth 1.
module tb_reg_incr_nstage_pipe;

   localparam int W  = 8;
   localparam int N  = 3;
   localparam int A  = 1;
   localparam int W1 = 4;
   localparam int N1 = 1;
   localparam int A1 = 5;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_val = 1'b0;
   logic         in_rdy;
   logic [W-1:0] in_msg = '0;
   logic         out_val;
   logic         out_rdy = 1'b0;
   logic [W-1:0] out_msg;
   logic [1:0]   count;

   logic          d1_in_val = 1'b0;
   logic          d1_in_rdy;
   logic [W1-1:0] d1_in_msg = '0;
   logic          d1_out_val;
   logic          d1_out_rdy = 1'b0;
   logic [W1-1:0] d1_out_msg;
   logic          d1_count;

   int n_chk  = 0;
   int n_pass = 0;

   logic [W-1:0] exp_q [$];
   logic         obs_val;
   logic         obs_rdy;
   logic [W-1:0] obs_msg;
   logic [1:0]   obs_cnt;

   always #5 clk = ~clk;

   reg_incr_nstage_pipe #(
      .WIDTH    (W),
      .NSTAGES  (N),
      .INCR_AMT (A)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in_msg  (in_msg),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out_msg (out_msg),
      .count   (count)
   );

   reg_incr_nstage_pipe #(
      .WIDTH    (W1),
      .NSTAGES  (N1),
      .INCR_AMT (A1)
   ) dut1 (
      .clk     (clk),
      .reset   (reset),
      .in_val  (d1_in_val),
      .in_rdy  (d1_in_rdy),
      .in_msg  (d1_in_msg),
      .out_val (d1_out_val),
      .out_rdy (d1_out_rdy),
      .out_msg (d1_out_msg),
      .count   (d1_count)
   );

   // Whole-pipe result: N additions of A, then wrap or clamp at 2^w - 1.
   function automatic int ref_out(int x, int n, int amt, int w);
      int s;
      int top;
      s   = x + n * amt;
      top = (1 << w) - 1;
`ifdef REG_INCR_NSTAGE_PIPE_SAT_EN
      return (s > top) ? top : s;
`else
      return s % (1 << w);
`endif
   endfunction

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One cycle: drive at negedge, check against model, advance model at edge.
   task automatic drive(
      input logic         iv,
      input logic [W-1:0] im,
      input logic         ordy
   );
      logic rdy_exp;
      @(negedge clk);
      in_val  = iv;
      in_msg  = im;
      out_rdy = ordy;
      #1;
      obs_val = out_val;
      obs_rdy = in_rdy;
      obs_msg = out_msg;
      obs_cnt = count;
      rdy_exp = (exp_q.size() < N) || ordy;
      chk("in_rdy", 32'(in_rdy), 32'(rdy_exp));
      chk("count", 32'(count), 32'(exp_q.size()));
      if (out_val) begin
         chk("out_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0)
            chk("out_msg", 32'(out_msg), 32'(exp_q[0]));
      end
      @(posedge clk);
      if (out_val && ordy && exp_q.size() != 0)
         void'(exp_q.pop_front());
      if (iv && rdy_exp)
         exp_q.push_back(W'(ref_out(int'(im), N, A, W)));
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         drive(1'b0, '0, 1'b1);
         k++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_val", 32'(out_val), 32'd0);
      chk("rst_cnt", 32'(count), 32'd0);

      // Latency
      drive(1'b1, 8'h05, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, '0, 1'b1);
         if (k < 3) chk("lat_early", 32'(obs_val), 32'd0);
         if (k < 4) chk("lat_cnt", 32'(obs_cnt), 32'd1);
         if (k == 3) begin
            chk("lat_val", 32'(obs_val), 32'd1);
            chk("lat_msg", 32'(obs_msg), 32'h08);
         end
         if (k == 4) chk("lat_cnt0", 32'(obs_cnt), 32'd0);
      end

      // Wrap / saturate
      drive(1'b1, 8'hFE, 1'b1);
      for (int k = 1; k <= 3; k++) drive(1'b0, '0, 1'b1);
      chk("wrap_val", 32'(obs_val), 32'd1);
`ifdef REG_INCR_NSTAGE_PIPE_SAT_EN
      chk("sat_msg", 32'(obs_msg), 32'hFF);
`else
      chk("wrap_msg", 32'(obs_msg), 32'h01);
`endif
      drain("wrap_drain");

      // Streaming
      for (int k = 0; k < 14; k++) begin
         drive(k < 10, W'(k), 1'b1);
         chk("stream_rdy", 32'(obs_rdy), 32'd1);
         if (k < 3) chk("stream_gap", 32'(obs_val), 32'd0);
         else if (k <= 12) begin
            chk("stream_val", 32'(obs_val), 32'd1);
            chk("stream_msg", 32'(obs_msg), 32'(k));
         end
      end
      drain("stream_drain");

      // Backpressure
      drive(1'b1, 8'h10, 1'b0);
      drive(1'b1, 8'h20, 1'b0);
      drive(1'b1, 8'h30, 1'b0);
      drive(1'b1, 8'h40, 1'b0);
      chk("bp_rdy_low", 32'(obs_rdy), 32'd0);
      chk("bp_cnt3", 32'(obs_cnt), 32'd3);
      drive(1'b1, 8'h40, 1'b1);
      chk("bp_rdy_hi", 32'(obs_rdy), 32'd1);
      chk("bp_first", 32'(obs_msg), 32'h13);
      drive(1'b0, '0, 1'b1);
      chk("bp_cnt_keep", 32'(obs_cnt), 32'd3);
      chk("bp_second", 32'(obs_msg), 32'h23);
      drain("bp_drain");

      // Mid-operation reset
      drive(1'b1, 8'h50, 1'b1);
      drive(1'b1, 8'h60, 1'b1);
      @(negedge clk);
      in_val = 1'b0;
      reset  = 1'b1;
      @(posedge clk);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mrst_val", 32'(out_val), 32'd0);
      chk("mrst_cnt", 32'(count), 32'd0);
      drive(1'b1, 8'h07, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, '0, 1'b1);
         if (k < 3) chk("mrst_quiet", 32'(obs_val), 32'd0);
      end
      chk("mrst_val2", 32'(obs_val), 32'd1);
      chk("mrst_msg", 32'(obs_msg), 32'h0A);
      drain("mrst_drain");

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 1)), W'($urandom),
               $urandom_range(0, 9) < 7);
         chk("rand_cnt_max", 32'(obs_cnt <= 2'(N)), 32'd1);
      end
      drain("rand_drain");

      // Depth-1 instance
      @(negedge clk);
      d1_in_val  = 1'b1;
      d1_in_msg  = 4'hC;
      d1_out_rdy = 1'b1;
      #1;
      chk("d1_rdy", 32'(d1_in_rdy), 32'd1);
      chk("d1_cnt0", 32'(d1_count), 32'd0);
      @(negedge clk);
      d1_in_val  = 1'b0;
      d1_out_rdy = 1'b0;
      #1;
      chk("d1_val", 32'(d1_out_val), 32'd1);
      chk("d1_msg", 32'(d1_out_msg),
          32'(ref_out(12, N1, A1, W1)));
      chk("d1_cnt1", 32'(d1_count), 32'd1);
      chk("d1_full", 32'(d1_in_rdy), 32'd0);
      @(negedge clk);
      d1_out_rdy = 1'b1;
      #1;
      chk("d1_hold", 32'(d1_out_val), 32'd1);
      chk("d1_hmsg", 32'(d1_out_msg),
          32'(ref_out(12, N1, A1, W1)));
      chk("d1_hcnt", 32'(d1_count), 32'd1);
      @(negedge clk);
      #1;
      chk("d1_gone", 32'(d1_out_val), 32'd0);
      chk("d1_cnt_end", 32'(d1_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
